// File: rtl/binary_search_ctrl_if.sv
// binary_search_ctrl_if: search request, comparator flags and result bus (slave = controller, master = requester/comparator)
interface binary_search_ctrl_if;
  logic       start;
  logic       A_lt_B;
  logic       A_gt_B;
  logic       A_eq_B;
  logic [7:0] guess;
  logic       busy;
  logic       done;
  logic       found;
  logic       err;
  logic [7:0] result;
  logic [3:0] steps;
  modport slave (
    input  start, A_lt_B, A_gt_B, A_eq_B,
    output guess, busy, done, found, err, result, steps
  );
  modport master (
    output start, A_lt_B, A_gt_B, A_eq_B,
    input  guess, busy, done, found, err, result, steps
  );
endinterface

// File: rtl/binary_search_ctrl.sv
// binary_search_ctrl: 8-bit binary search over an external comparator; clk/rst plus bus (start, flags in; guess, busy, done, found, err, result, steps out)
module binary_search_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  binary_search_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PROBE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  logic [1:0] state;
  logic [7:0] lo, hi, n_lo, n_hi;
  logic [8:0] sum;
  logic [3:0] cnt;
  logic       lt, gt, eq, one_hot, sample, bad;
  assign lt      = bus.A_lt_B;
  assign gt      = bus.A_gt_B;
  assign eq      = bus.A_eq_B;
  assign one_hot = {lt, gt, eq} inside {3'b100, 3'b010, 3'b001};
  assign sample  = (state == PROBE && WAIT_CYCLES == 1) ||
                   (state == WAIT && cnt == 4'(WAIT_CYCLES - 2));
  assign n_lo    = gt ? bus.guess + 8'd1 : lo;
  assign n_hi    = lt ? bus.guess - 8'd1 : hi;
  assign sum     = {1'b0, n_lo} + {1'b0, n_hi};
  assign bad     = !one_hot || (lt && bus.guess == 8'd0) ||
                   (gt && bus.guess == 8'hff) || n_lo > n_hi;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lo         <= 8'd0;
      hi         <= 8'hff;
      cnt        <= 4'd0;
      bus.guess  <= 8'd0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.found  <= 1'b0;
      bus.err    <= 1'b0;
      bus.result <= 8'd0;
      bus.steps  <= 4'd0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          state      <= PROBE;
          lo         <= 8'd0;
          hi         <= 8'hff;
          bus.guess  <= 8'd127;
          bus.busy   <= 1'b1;
          bus.found  <= 1'b0;
          bus.err    <= 1'b0;
          bus.result <= 8'd0;
          bus.steps  <= 4'd0;
        end
      end else if (state == PROBE && WAIT_CYCLES > 1) begin
        state <= WAIT;
        cnt   <= 4'd0;
      end else if (!sample) begin
        cnt <= cnt + 4'd1;
      end else begin
        bus.steps <= bus.steps + 4'd1;
        if (bad || eq) begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b1;
          bus.err    <= bad;
          bus.found  <= !bad;
          bus.result <= bad ? 8'd0 : bus.guess;
        end else begin
          state     <= PROBE;
          lo        <= n_lo;
          hi        <= n_hi;
          bus.guess <= sum[8:1];
        end
      end
    end
  end
endmodule

// File: tb/tb_binary_search_ctrl.sv
// tb_binary_search_ctrl: randomized and directed checks of binary_search_ctrl at WAIT_CYCLES 1 and 3 against an arithmetic search model
module tb_binary_search_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [7:0] tgt = 8'd0;
  logic [1:0] mode = 2'd0;
  int checks = 0;
  int errors = 0;
  binary_search_ctrl_if b1 ();
  binary_search_ctrl_if b3 ();
  binary_search_ctrl #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  binary_search_ctrl #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  always #5 clk = ~clk;
  assign b1.start = start & ~sel;
  assign b3.start = start & sel;
  assign b1.A_lt_B = mode == 2'd1 || mode == 2'd3 || (mode == 2'd0 && tgt < b1.guess);
  assign b1.A_gt_B = mode == 2'd1 || mode == 2'd2 || (mode == 2'd0 && tgt > b1.guess);
  assign b1.A_eq_B = mode == 2'd0 && tgt == b1.guess;
  assign b3.A_lt_B = mode == 2'd1 || mode == 2'd3 || (mode == 2'd0 && tgt < b3.guess);
  assign b3.A_gt_B = mode == 2'd1 || mode == 2'd2 || (mode == 2'd0 && tgt > b3.guess);
  assign b3.A_eq_B = mode == 2'd0 && tgt == b3.guess;
  logic [7:0] guess, result;
  logic [3:0] steps;
  logic busy, done, found, err;
  assign guess  = sel ? b3.guess  : b1.guess;
  assign result = sel ? b3.result : b1.result;
  assign steps  = sel ? b3.steps  : b1.steps;
  assign busy   = sel ? b3.busy   : b1.busy;
  assign done   = sel ? b3.done   : b1.done;
  assign found  = sel ? b3.found  : b1.found;
  assign err    = sel ? b3.err    : b1.err;
  task automatic check_idle_reset(input string name);
    checks++;
    if ({guess, result, steps, busy, done, found, err} !== 24'd0) begin
      errors++;
      $display("FAIL %s: guess=%0d result=%0d steps=%0d busy=%b done=%b found=%b err=%b, required all zero",
               name, guess, result, steps, busy, done, found, err);
    end
  endtask
  task automatic run_search(input logic s, input logic [7:0] t, input logic [1:0] m);
    int w, lo, hi, g, n;
    int q[$];
    bit lt, gt, eq, e_err;
    w = s ? 3 : 1;
    lo = 0;
    hi = 255;
    e_err = 0;
    forever begin
      g = (lo + hi) / 2;
      q.push_back(g);
      lt = (m == 1) || (m == 3) || (m == 0 && t < g);
      gt = (m == 1) || (m == 2) || (m == 0 && t > g);
      eq = (m == 0 && t == g);
      if (int'(lt) + int'(gt) + int'(eq) != 1) begin e_err = 1; break; end
      if (eq) break;
      if (lt) begin
        if (g == 0) begin e_err = 1; break; end
        hi = g - 1;
      end else begin
        if (g == 255) begin e_err = 1; break; end
        lo = g + 1;
      end
      if (lo > hi) begin e_err = 1; break; end
    end
    n = q.size();
    sel = s;
    tgt = t;
    mode = m;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1 || guess !== 8'd127 || done !== 1'b0 || found !== 1'b0 || err !== 1'b0 || steps !== 4'd0 || result !== 8'd0) begin
      errors++;
      $display("FAIL start_w%0d_t%0d: busy=%b guess=%0d done=%b found=%b err=%b steps=%0d result=%0d, required busy=1 guess=127 rest 0",
               w, t, busy, guess, done, found, err, steps, result);
    end
    for (int c = 1; c <= n * w; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (c < n * w) begin
        if (done !== 1'b0 || busy !== 1'b1 || guess !== 8'(q[c / w])) begin
          errors++;
          $display("FAIL probe_w%0d_t%0d_c%0d: done=%b busy=%b guess=%0d, required done=0 busy=1 guess=%0d",
                   w, t, c, done, busy, guess, q[c / w]);
        end
      end else if (done !== 1'b1 || busy !== 1'b0 || found !== !e_err || err !== e_err ||
                   steps !== 4'(n) || guess !== 8'(q[n - 1]) || result !== (e_err ? 8'd0 : 8'(q[n - 1]))) begin
        errors++;
        $display("FAIL finish_w%0d_t%0d_m%0d: done=%b busy=%b found=%b err=%b steps=%0d guess=%0d result=%0d, required done=1 busy=0 found=%b err=%b steps=%0d guess=%0d result=%0d",
                 w, t, m, done, busy, found, err, steps, guess, result, !e_err, e_err, n, q[n - 1], e_err ? 0 : q[n - 1]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || found !== !e_err || err !== e_err || steps !== 4'(n) || guess !== 8'(q[n - 1])) begin
      errors++;
      $display("FAIL hold_w%0d_t%0d: done=%b busy=%b found=%b err=%b steps=%0d guess=%0d, required done=0 busy=0 found=%b err=%b steps=%0d guess=%0d",
               w, t, done, busy, found, err, steps, guess, !e_err, e_err, n, q[n - 1]);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    check_idle_reset("reset_w1");
    sel = 1'b1;
    check_idle_reset("reset_w3");
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic test_directed;
    run_search(1'b0, 8'd127, 2'd0);
    run_search(1'b0, 8'd0, 2'd0);
    run_search(1'b0, 8'd255, 2'd0);
    run_search(1'b1, 8'd200, 2'd0);
    run_search(1'b1, 8'd255, 2'd0);
  endtask
  task automatic test_bad_flags;
    run_search(1'b0, 8'd0, 2'd1);
    run_search(1'b1, 8'd0, 2'd1);
    run_search(1'b0, 8'd0, 2'd2);
    run_search(1'b0, 8'd0, 2'd3);
    run_search(1'b1, 8'd0, 2'd2);
  endtask
  task automatic test_random;
    for (int i = 0; i < 16; i++)
      run_search(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 2'd0);
  endtask
  task automatic test_mid_reset;
    sel = 1'b0;
    tgt = 8'd255;
    mode = 2'd0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 check_idle_reset("mid_reset_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_idle_reset("mid_reset_held");
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check_idle_reset("mid_reset_release");
    run_search(1'b0, 8'd42, 2'd0);
  endtask
  task automatic test_back_to_back;
    sel = 1'b0;
    tgt = 8'd127;
    mode = 2'd0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || found !== 1'b1 || steps !== 4'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: done=%b found=%b steps=%0d busy=%b, required 1 1 1 0", done, found, steps, busy);
    end
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || found !== 1'b0 || steps !== 4'd0 || guess !== 8'd127) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b found=%b steps=%0d guess=%0d, required 1 0 0 0 127", busy, done, found, steps, guess);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || found !== 1'b1 || result !== 8'd127 || steps !== 4'd1) begin
      errors++;
      $display("FAIL b2b_second: done=%b found=%b result=%0d steps=%0d, required 1 1 127 1", done, found, result, steps);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_bad_flags();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/binary_search_ctrl.md
BINARY_SEARCH_CTRL -- requirements
Module: binary_search_ctrl

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 1, meaning cycles each probe value is held before comparator flags are sampled (legal range 1..15).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL provide port start, input, 1, request a new search; sampled only in IDLE.
REQ-005 SHALL provide port A_lt_B, input, 1, comparator flag, target < guess.
REQ-006 SHALL provide port A_gt_B, input, 1, comparator flag, target > guess.
REQ-007 SHALL provide port A_eq_B, input, 1, comparator flag, target == guess.
REQ-008 SHALL provide port guess, output, 8, registered probe value driven to the comparator B input.
REQ-009 SHALL provide port busy, output, 1, high while a search is in progress.
REQ-010 SHALL provide port done, output, 1, one-cycle pulse when a search terminates.
REQ-011 SHALL provide ports found (output, 1), err (output, 1), result (output, 8), steps (output, 4); all are registered and hold their values until the next start.

Function
REQ-012 SHALL implement FSM states IDLE, PROBE, WAIT; transitions: IDLE->PROBE on start; PROBE->WAIT when WAIT_CYCLES>1; WAIT->PROBE after WAIT_CYCLES-1 cycles; PROBE->IDLE on termination.
REQ-013 SHALL, on the edge accepting start, set lo=0 and hi=255, drive guess=127, set busy=1, and clear found, err, steps and result.
REQ-014 SHALL sample the comparator flags WAIT_CYCLES rising edges after each guess update; each sample increments steps.
REQ-015 SHALL compute the next guess as (lo+hi)>>1 using a 9-bit sum with no overflow; lo and hi are 8-bit registers.
REQ-016 SHALL, on a sample with A_eq_B only, terminate with found=1 and result=guess.
REQ-017 SHALL, on a sample with A_lt_B only, set hi=guess-1; on A_gt_B only, set lo=guess+1; it then drives the new guess.
REQ-018 SHALL terminate with err=1 and found=0 if the flags are not exactly one-hot, if A_lt_B is asserted with guess==0, if A_gt_B is asserted with guess==255, or if the updated lo>hi.
REQ-019 SHALL, on the termination edge, set busy=0 and done=1; done clears on the following edge.
REQ-020 SHALL ignore start while busy=1; start is accepted in the cycle done=1, because the FSM is already in IDLE.
REQ-021 SHALL hold guess at its last value in IDLE.
REQ-022 SHALL never exceed 9 samples per search, so steps is always <= 9.
REQ-023 SHALL make a search of N samples complete N*WAIT_CYCLES cycles after the start edge.

Reset
REQ-024 SHALL, while rst=1 and regardless of clk, force state=IDLE and guess=0, lo=0, hi=255, busy=0, done=0, found=0, err=0, result=0, steps=0.
REQ-025 SHALL, on rst asserted mid-search, abandon the search without a done pulse; the first start after rst deasserts begins a fresh search.

Verification
REQ-026 SHALL cover: WAIT_CYCLES=1, target 127 -> one sample, done 1 cycle after the start edge, found=1, result=127, steps=1.
REQ-027 SHALL cover: target 0 -> guesses 127,63,31,15,7,3,1,0; found=1, result=0, steps=8.
REQ-028 SHALL cover: target 255 -> guesses 127,191,223,239,247,251,253,254,255; found=1, result=255, steps=9, done at cycle 9.
REQ-029 SHALL cover: WAIT_CYCLES=3, target 200 -> flags sampled only every 3rd edge, found=1, result=200, done = steps*3 cycles after the start edge.
REQ-030 SHALL cover: flags forced to lt=1 and gt=1 on the first sample -> done=1, err=1, found=0, steps=1.
REQ-031 SHALL cover: rst asserted at step 4, then start with target 42 -> outputs at reset values with no done pulse, then a clean search giving result=42, found=1.
